// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds a shadow copy of the value and lights one digit per refresh period.
module display_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_ZEROS = 1,
   localparam int DPW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digitsIn,
   input  logic                    negIn,
   input  logic                    dpEn,
   input  logic [DPW-1:0]          dpPos,
   output logic [3:0]              digit,
   output logic                    decPointFlag,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    signDropped
);

   localparam int DIVW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(REFRESH_DIV - 1);
   localparam logic [DPW-1:0]  IDX_LAST = DPW'(NUM_DIGITS - 1);
   localparam logic [3:0]      CODE_MINUS = 4'hA;
   localparam logic [3:0]      CODE_BLANK = 4'hF;

   logic [DIVW-1:0]         div_cnt;
   logic [DPW-1:0]          idx;
   logic                    tick;

   logic [4*NUM_DIGITS-1:0] val_q;
   logic                    neg_q;
   logic                    dp_en_q;
   logic [DPW-1:0]          dp_pos_q;
   logic                    load_q;

   logic [DPW-1:0]          msd;
   logic [DPW-1:0]          top;
   logic [DPW:0]            top_p1;
   logic                    value_nz;
   logic [3:0]              top_nib;
   logic                    sign_blocked;
   logic                    drop_sign;
   logic [3:0]              nib;
   logic [3:0]              nib_code;
   logic [3:0]              code;
   logic                    dp_here;
   logic [NUM_DIGITS-1:0]   one_hot;
   logic [NUM_DIGITS-1:0]   anode_next;

   assign tick = (div_cnt == DIV_LAST);

   // load is a single-cycle strobe with no back-pressure: every cycle it is high,
   // the inputs are taken into the shadow at that rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q    <= '0;
         neg_q    <= 1'b0;
         dp_en_q  <= 1'b0;
         dp_pos_q <= '0;
         load_q   <= 1'b0;
      end else begin
         load_q <= load;
         if (load) begin
            val_q    <= digitsIn;
            neg_q    <= negIn;
            dp_en_q  <= dpEn && (int'(dpPos) < NUM_DIGITS);
            dp_pos_q <= dpPos;
         end
      end
   end

   always_comb begin
      msd      = '0;
      nib      = 4'h0;
      value_nz = |val_q;
      top_nib  = val_q[4*(NUM_DIGITS-1) +: 4];
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (val_q[4*i +: 4] != 4'h0) msd = DPW'(i);
         if (DPW'(i) == idx) nib = val_q[4*i +: 4];
      end

      top    = (dp_en_q && (dp_pos_q > msd)) ? dp_pos_q : msd;
      top_p1 = {1'b0, top} + 1'b1;

      // With blanking the sign sits just above the top digit; without it the
      // sign can only borrow the most significant position when that is zero.
      if (BLANK_ZEROS != 0) sign_blocked = (top == IDX_LAST);
      else                  sign_blocked = (top_nib != 4'h0);
      drop_sign = neg_q && value_nz && sign_blocked;

      nib_code = (nib > 4'd9) ? CODE_BLANK : nib;
      code     = CODE_BLANK;
      if (BLANK_ZEROS == 0) begin
         if ((idx == IDX_LAST) && neg_q && value_nz && (top_nib == 4'h0)) code = CODE_MINUS;
         else                                                             code = nib_code;
      end else if (idx <= top) begin
         code = nib_code;
      end else if (neg_q && value_nz && ({1'b0, idx} == top_p1)) begin
         code = CODE_MINUS;
      end

      dp_here    = dp_en_q && (dp_pos_q == idx);
      one_hot    = NUM_DIGITS'(1) << idx;
      anode_next = ~one_hot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt      <= '0;
         idx          <= '0;
         digit        <= CODE_BLANK;
         decPointFlag <= 1'b0;
         anode        <= '1;
      end else if (tick) begin
         div_cnt      <= '0;
         digit        <= code;
         decPointFlag <= dp_here;
         anode        <= anode_next;
         idx          <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Evaluated the cycle after a capture so it reflects the freshly loaded shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) signDropped <= 1'b0;
      else if (load_q) signDropped <= drop_sign;
   end

endmodule
